// File: rtl/a_rf_loader.sv
// a_rf_loader: upstream sequencer for the 8-entry A-operand register file of
// the DSP slice. It shifts a block of operands into the file, then replays
// the read addresses oldest-first for a programmable number of passes. This
// lets FIR taps and convolution windows reuse operands.
//
// Ports
//   CLK, RSTA          clock; asynchronous active-high reset
//   cfg_start          start pulse, sampled only in IDLE
//   cfg_len[3:0]       operands to load (1..8)
//   cfg_mdr            dual-read mode (cfg_len must be even)
//   cfg_passes[7:0]    read passes minus 1
//   in_valid/in_data   upstream operand stream
//   in_ready           operand accepted this cycle
//   A, RF_load         register-file shift data and enable (registered)
//   r_addr, MDRr       register-file read address and dual-read select
//   rd_valid           r_addr/MDRr select a valid operand (pair)
//   busy, done, err    status: not IDLE / end of final pass / bad config
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for cfg_start; a bad configuration pulses err
// LOAD  | accepting cfg_len operands, one shift per handshake
// DRAIN | one gap cycle while the file captures the final word
// READ  | replaying addresses newest-index-last, cfg_passes+1 times
// FIN   | done pulse, then back to IDLE

module a_rf_loader #(
    parameter int RF_DEPTH = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 27
) (
    input  logic              CLK,
    input  logic              RSTA,
    input  logic              cfg_start,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_mdr,
    input  logic [7:0]        cfg_passes,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] A,
    output logic              RF_load,
    output logic [ADDR_W-1:0] r_addr,
    output logic              MDRr,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_READ,
        S_FIN
    } state_t;

    localparam logic [3:0] DEPTH_L = 4'(RF_DEPTH);

    state_t            state;
    logic [3:0]        len_q;
    logic              mdr_q;
    logic [7:0]        passes_q;
    logic [3:0]        ld_cnt;
    logic [7:0]        pass_cnt;

    logic              hs;
    logic              cfg_illegal;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] addr_step;

    assign hs          = in_valid & in_ready;
    assign cfg_illegal = (cfg_len == 4'd0) || (cfg_len > DEPTH_L) ||
                         (cfg_mdr && cfg_len[0]);

    // The first word loaded ends up at index len-1, so the oldest-first replay
    // starts there (or one lower in dual mode, where the pair is addr, addr+1).
    assign first_addr = ADDR_W'(len_q - (mdr_q ? 4'd2 : 4'd1));
    assign addr_step  = mdr_q ? ADDR_W'(2) : ADDR_W'(1);

    always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            state    <= S_IDLE;
            len_q    <= '0;
            mdr_q    <= 1'b0;
            passes_q <= '0;
            ld_cnt   <= '0;
            pass_cnt <= '0;
            in_ready <= 1'b0;
            A        <= '0;
            RF_load  <= 1'b0;
            r_addr   <= '0;
            MDRr     <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        len_q    <= cfg_len;
                        mdr_q    <= cfg_mdr;
                        passes_q <= cfg_passes;
                        if (cfg_illegal) begin
                            err <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            ld_cnt   <= '0;
                        end
                    end
                end

                S_LOAD: begin
                    RF_load <= hs;
                    if (hs) begin
                        A      <= in_data;
                        ld_cnt <= ld_cnt + 4'd1;
                        if (ld_cnt + 4'd1 == len_q) begin
                            in_ready <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                end

                // RF_load is still high from the last handshake; the file
                // captures that word at the end of this cycle.
                S_DRAIN: begin
                    RF_load  <= 1'b0;
                    r_addr   <= first_addr;
                    MDRr     <= mdr_q;
                    rd_valid <= 1'b1;
                    pass_cnt <= '0;
                    state    <= S_READ;
                end

                S_READ: begin
                    if (r_addr == '0) begin
                        if (pass_cnt == passes_q) begin
                            rd_valid <= 1'b0;
                            MDRr     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            pass_cnt <= pass_cnt + 8'd1;
                            r_addr   <= first_addr;
                        end
                    end else begin
                        r_addr <= r_addr - addr_step;
                    end
                end

                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a_rf_loader.sv
// Self-checking bench for a_rf_loader. A behavioural 8-entry shift register
// stands in for the A-operand file so replayed data can be checked.

module tb_a_rf_loader;

    logic        CLK = 1'b0;
    logic        RSTA;
    logic        cfg_start;
    logic [3:0]  cfg_len;
    logic        cfg_mdr;
    logic [7:0]  cfg_passes;
    logic        in_valid;
    logic [26:0] in_data;
    logic        in_ready;
    logic [26:0] A;
    logic        RF_load;
    logic [2:0]  r_addr;
    logic        MDRr;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_k    = 0;

    logic [26:0] rf [8];

    always #5 CLK = ~CLK;

    a_rf_loader dut (
        .CLK        (CLK),
        .RSTA       (RSTA),
        .cfg_start  (cfg_start),
        .cfg_len    (cfg_len),
        .cfg_mdr    (cfg_mdr),
        .cfg_passes (cfg_passes),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .A          (A),
        .RF_load    (RF_load),
        .r_addr     (r_addr),
        .MDRr       (MDRr),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Register-file model: newest word at index 0.
    always @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (RF_load) begin
            rf[0] <= A;
            for (int i = 1; i < 8; i++) rf[i] <= rf[i-1];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, want end of test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cur_k, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 0);
        check({tag, " A"},        32'(A),        0);
        check({tag, " RF_load"},  32'(RF_load),  0);
        check({tag, " r_addr"},   32'(r_addr),   0);
        check({tag, " MDRr"},     32'(MDRr),     0);
        check({tag, " rd_valid"}, 32'(rd_valid), 0);
        check({tag, " busy"},     32'(busy),     0);
        check({tag, " done"},     32'(done),     0);
        check({tag, " err"},      32'(err),      0);
    endtask

    // Returns at the falling edge of the first cycle after the start edge.
    task automatic start_cfg(input int len, input bit mdr, input int passes);
        @(negedge CLK);
        cfg_len    = 4'(len);
        cfg_mdr    = mdr;
        cfg_passes = 8'(passes);
        cfg_start  = 1'b1;
        @(negedge CLK);
        cfg_start  = 1'b0;
        cur_k      = 1;
    endtask

    typedef struct {
        int len;
        bit mdr;
        int passes;
        int scale;    // operand i (0-based) = scale*(i+1)
        bit exp_err;
        bit poke;     // assert cfg_start with len=3 during READ
    } vec_t;

    // Full cycle-by-cycle expectation for one start with back-to-back input.
    task automatic run(input vec_t v);
        logic [26:0] d [8];
        int n, rr, total, j, ea, idx;
        bit e_rv;
        for (int i = 0; i < 8; i++) d[i] = 27'(v.scale * (i + 1));
        start_cfg(v.len, v.mdr, v.passes);
        if (v.exp_err) begin
            check("err pulse", 32'(err), 1);
            check("err busy", 32'(busy), 0);
            check("err in_ready", 32'(in_ready), 0);
            @(negedge CLK);
            check("err one cycle", 32'(err), 0);
            check("err busy after", 32'(busy), 0);
            check("err in_ready after", 32'(in_ready), 0);
            return;
        end
        n     = v.mdr ? v.len / 2 : v.len;
        rr    = (v.passes + 1) * n;
        total = v.len + 3 + rr;
        for (int k = 1; k <= total; k++) begin
            if (k > 1) @(negedge CLK);
            cur_k = k;
            e_rv  = (k >= v.len + 2) && (k <= v.len + 1 + rr);
            check("busy",     32'(busy),     32'(k <= v.len + 2 + rr));
            check("in_ready", 32'(in_ready), 32'(k <= v.len));
            check("RF_load",  32'(RF_load),  32'(k >= 2 && k <= v.len + 1));
            if (k >= 2)
                check("A", 32'(A), 32'(d[(k - 2 < v.len - 1) ? k - 2 : v.len - 1]));
            check("rd_valid", 32'(rd_valid), 32'(e_rv));
            check("done",     32'(done),     32'(k == v.len + 2 + rr));
            check("err idle", 32'(err),      0);
            if (e_rv) begin
                j  = (k - v.len - 2) % n;
                ea = v.mdr ? v.len - 2 - 2 * j : v.len - 1 - j;
                check("r_addr", 32'(r_addr), 32'(ea));
                check("MDRr",   32'(MDRr),   32'(v.mdr));
                idx = int'(r_addr);
                if (v.mdr) begin
                    check("file hi", 32'(rf[idx]), 32'(d[2 * j + 1]));
                    if (idx < 7) check("file lo", 32'(rf[idx + 1]), 32'(d[2 * j]));
                end else begin
                    check("file", 32'(rf[idx]), 32'(d[j]));
                end
            end else begin
                check("r_addr idle", 32'(r_addr), 0);
                check("MDRr idle",   32'(MDRr),   0);
            end
            // drive for the next edge
            in_valid = (k <= v.len);
            in_data  = (k <= v.len) ? d[k - 1] : 27'h1ABCDE;
            if (v.poke && k == v.len + 3) begin
                cfg_start = 1'b1;
                cfg_len   = 4'd3;
            end else begin
                cfg_start = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        logic [26:0] bd [3];
        int acc;
        bit hs;

        RSTA = 1'b1; cfg_start = 0; cfg_len = 0; cfg_mdr = 0; cfg_passes = 0;
        in_valid = 0; in_data = 0;
        repeat (2) @(negedge CLK);
        check_all_zero("reset");
        RSTA = 1'b0;

        vecs[0] = '{len: 4, mdr: 0, passes: 0, scale: 10, exp_err: 0, poke: 0};
        vecs[1] = '{len: 8, mdr: 1, passes: 2, scale: 1,  exp_err: 0, poke: 0};
        vecs[2] = '{len: 0, mdr: 0, passes: 0, scale: 1,  exp_err: 1, poke: 0};
        vecs[3] = '{len: 9, mdr: 0, passes: 0, scale: 1,  exp_err: 1, poke: 0};
        vecs[4] = '{len: 5, mdr: 1, passes: 0, scale: 1,  exp_err: 1, poke: 0};
        vecs[5] = '{len: 1, mdr: 0, passes: 3, scale: 7,  exp_err: 0, poke: 0};
        vecs[6] = '{len: 2, mdr: 1, passes: 1, scale: 9,  exp_err: 0, poke: 0};
        vecs[7] = '{len: 4, mdr: 0, passes: 1, scale: 3,  exp_err: 0, poke: 1};
        for (int i = 0; i < 8; i++) run(vecs[i]);

        // Bubbled input, len=3: valid on alternate cycles.
        for (int i = 0; i < 3; i++) bd[i] = 27'(100 * (i + 1));
        acc = 0;
        hs  = 1'b0;
        start_cfg(3, 0, 0);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge CLK);
            cur_k = c + 1;
            check("bub RF_load", 32'(RF_load), 32'(hs));
            if (acc > 0) check("bub A", 32'(A), 32'(bd[acc - 1]));
            check("bub in_ready", 32'(in_ready), 32'(acc < 3));
            check("bub rd_valid", 32'(rd_valid), 0);
            if (acc == 3) break;
            in_valid = (c % 2 == 0);
            in_data  = in_valid ? bd[acc] : 27'h5A5A5A;
            hs       = in_valid;
            if (hs) acc++;
        end
        check("bub beats", 32'(acc), 3);
        in_valid = 1'b0;
        for (int r = 2; r >= 0; r--) begin
            @(negedge CLK);
            check("bub rd_valid read", 32'(rd_valid), 1);
            check("bub r_addr", 32'(r_addr), 32'(r));
            check("bub file", 32'(rf[r]), 32'(bd[2 - r]));
        end
        @(negedge CLK);
        check("bub done", 32'(done), 1);
        @(negedge CLK);
        check("bub idle", 32'(busy), 0);

        // Asynchronous reset during LOAD after two beats.
        start_cfg(4, 0, 0);
        in_valid = 1'b1; in_data = 27'd11;
        @(negedge CLK);
        in_data = 27'd12;
        @(negedge CLK);
        check("pre-rst RF_load", 32'(RF_load), 1);
        check("pre-rst A", 32'(A), 12);
        in_data = 27'd13;
        #2 RSTA = 1'b1;
        #1 check_all_zero("async rst");
        @(negedge CLK);
        RSTA = 1'b0;
        in_valid = 1'b0;
        run('{len: 2, mdr: 0, passes: 0, scale: 5, exp_err: 0, poke: 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
